// File: rtl/fb_spi_pkg.sv
// Shared opcodes, decoder states and status-byte layout for the SPI framebuffer command writer.
package fb_spi_pkg;

  localparam int unsigned FbDepth = 76800;
  localparam int unsigned AddrW   = 17;

  localparam int unsigned StatusHblankBit = 0;
  localparam int unsigned StatusVblankBit = 1;
  localparam int unsigned StatusErrBit    = 2;
  localparam int unsigned StatusVerLsb    = 4;

  typedef enum logic [7:0] {
    OpWrRgb  = 8'h01,
    OpRdRgb  = 8'h02,
    OpWrPal  = 8'h03,
    OpRdPal  = 8'h04,
    OpStatus = 8'h05
  } opcode_e;

  typedef enum logic [3:0] {
    StIdle,
    StAddr2,
    StAddr1,
    StAddr0,
    StPidx,
    StWrRgb,
    StRdRgb,
    StWrPal,
    StRdPal,
    StStatus,
    StIgnore
  } state_e;

  function automatic logic [7:0] status_byte(input logic [3:0] version, input logic err,
                                             input logic vblank, input logic hblank);
    logic [7:0] s;
    s = '0;
    s[StatusVerLsb +: 4]  = version;
    s[StatusErrBit]       = err;
    s[StatusVblankBit]    = vblank;
    s[StatusHblankBit]    = hblank;
    return s;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single level signal entering the SPI clock domain.
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= STAGES'({sync_q, d_i});
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fb_spi_cmd_writer.sv
// Decodes SPI command bytes into framebuffer and palette reads/writes; returns readback and
// status bytes for the SPI slave to shift out.
module fb_spi_cmd_writer
  import fb_spi_pkg::*;
#(
  parameter int unsigned FB_DEPTH    = FbDepth,
  parameter int unsigned ADDR_W      = AddrW,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [3:0]  VERSION     = 4'h1
) (
  input  logic              clk_spi,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  output logic [ADDR_W-1:0] rgb_addr,
  output logic [7:0]        rgb_wdata,
  output logic              wren_rgb,
  input  logic [7:0]        rgb_rdata,
  output logic [7:0]        palette_addr,
  output logic [23:0]       palette_wdata,
  output logic              wren_palette,
  input  logic [23:0]       palette_rdata,
  input  logic              hblank_in,
  input  logic              vblank_in
);

  logic hblank_s, vblank_s;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync_hblank (
    .clk_i (clk_spi),
    .rst_ni(rst_n),
    .d_i   (hblank_in),
    .q_o   (hblank_s)
  );

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync_vblank (
    .clk_i (clk_spi),
    .rst_ni(rst_n),
    .d_i   (vblank_in),
    .q_o   (vblank_s)
  );

  state_e             state_q, state_d;
  logic               op_rd_q, op_rd_d;
  logic [15:0]        addr_shift_q, addr_shift_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         idx_q, idx_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [23:0]        pal_q, pal_d;
  logic               err_q, err_d;
  logic [1:0]         pend_q, pend_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               tx_valid_q, tx_valid_d;
  logic [ADDR_W-1:0]  rgb_addr_q, rgb_addr_d;
  logic [7:0]         rgb_wdata_q, rgb_wdata_d;
  logic               wren_rgb_q, wren_rgb_d;
  logic [7:0]         palette_addr_q, palette_addr_d;
  logic [23:0]        palette_wdata_q, palette_wdata_d;
  logic               wren_palette_q, wren_palette_d;

  logic [ADDR_W-1:0]  addr_loaded;
  logic               addr_oob;
  logic [ADDR_W-1:0]  addr_start;
  logic [ADDR_W-1:0]  addr_inc;

  // Upper address bits beyond ADDR_W are dropped by the truncating cast.
  assign addr_loaded = ADDR_W'({addr_shift_q, rx_byte});
  assign addr_oob    = (32'(addr_loaded) >= FB_DEPTH);
  assign addr_start  = addr_oob ? '0 : addr_loaded;
  assign addr_inc    = (addr_q == ADDR_W'(FB_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);

  always_ff @(posedge clk_spi) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      op_rd_q         <= 1'b0;
      addr_shift_q    <= '0;
      addr_q          <= '0;
      idx_q           <= '0;
      cnt_q           <= '0;
      pal_q           <= '0;
      err_q           <= 1'b0;
      pend_q          <= '0;
      tx_byte_q       <= '0;
      tx_valid_q      <= 1'b0;
      rgb_addr_q      <= '0;
      rgb_wdata_q     <= '0;
      wren_rgb_q      <= 1'b0;
      palette_addr_q  <= '0;
      palette_wdata_q <= '0;
      wren_palette_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      op_rd_q         <= op_rd_d;
      addr_shift_q    <= addr_shift_d;
      addr_q          <= addr_d;
      idx_q           <= idx_d;
      cnt_q           <= cnt_d;
      pal_q           <= pal_d;
      err_q           <= err_d;
      pend_q          <= pend_d;
      tx_byte_q       <= tx_byte_d;
      tx_valid_q      <= tx_valid_d;
      rgb_addr_q      <= rgb_addr_d;
      rgb_wdata_q     <= rgb_wdata_d;
      wren_rgb_q      <= wren_rgb_d;
      palette_addr_q  <= palette_addr_d;
      palette_wdata_q <= palette_wdata_d;
      wren_palette_q  <= wren_palette_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    op_rd_d         = op_rd_q;
    addr_shift_d    = addr_shift_q;
    addr_d          = addr_q;
    idx_d           = idx_q;
    cnt_d           = cnt_q;
    pal_d           = pal_q;
    err_d           = err_q;
    pend_d          = {pend_q[0], 1'b0};
    tx_byte_d       = tx_byte_q;
    tx_valid_d      = tx_valid_q;
    rgb_addr_d      = rgb_addr_q;
    rgb_wdata_d     = rgb_wdata_q;
    wren_rgb_d      = 1'b0;
    palette_addr_d  = palette_addr_q;
    palette_wdata_d = palette_wdata_q;
    wren_palette_d  = 1'b0;

    if (cs_n) begin
      // Deselect aborts everything in flight, including a pending fetch or partial triplet.
      state_d    = StIdle;
      tx_valid_d = 1'b0;
      pend_d     = '0;
      cnt_d      = '0;
    end else begin
      // Fetch pipeline: address presented at pend[0], memory data valid at pend[1].
      if (pend_q[1]) begin
        tx_valid_d = 1'b1;
        if (state_q == StRdPal) begin
          pal_d     = palette_rdata;
          tx_byte_d = palette_rdata[23:16];
        end else begin
          tx_byte_d = rgb_rdata;
        end
      end

      if (rx_valid) begin
        unique case (state_q)
          StIdle: begin
            cnt_d = '0;
            case (rx_byte)
              OpWrRgb: begin
                op_rd_d = 1'b0;
                state_d = StAddr2;
              end
              OpRdRgb: begin
                op_rd_d = 1'b1;
                state_d = StAddr2;
              end
              OpWrPal: begin
                op_rd_d = 1'b0;
                state_d = StPidx;
              end
              OpRdPal: begin
                op_rd_d = 1'b1;
                state_d = StPidx;
              end
              OpStatus: begin
                tx_byte_d  = status_byte(VERSION, err_q, vblank_s, hblank_s);
                tx_valid_d = 1'b1;
                state_d    = StStatus;
              end
              default: state_d = StIgnore;
            endcase
          end
          StAddr2: begin
            addr_shift_d = {8'h00, rx_byte};
            state_d      = StAddr1;
          end
          StAddr1: begin
            addr_shift_d = {addr_shift_q[7:0], rx_byte};
            state_d      = StAddr0;
          end
          StAddr0: begin
            addr_d = addr_start;
            if (addr_oob) begin
              err_d = 1'b1;
            end
            if (op_rd_q) begin
              rgb_addr_d = addr_start;
              pend_d[0]  = 1'b1;
              tx_valid_d = 1'b0;
              state_d    = StRdRgb;
            end else begin
              state_d = StWrRgb;
            end
          end
          StWrRgb: begin
            wren_rgb_d  = 1'b1;
            rgb_addr_d  = addr_q;
            rgb_wdata_d = rx_byte;
            addr_d      = addr_inc;
          end
          StRdRgb: begin
            tx_valid_d = 1'b0;
            addr_d     = addr_inc;
            rgb_addr_d = addr_inc;
            pend_d[0]  = 1'b1;
          end
          StPidx: begin
            idx_d = rx_byte;
            cnt_d = '0;
            if (op_rd_q) begin
              palette_addr_d = rx_byte;
              pend_d[0]      = 1'b1;
              tx_valid_d     = 1'b0;
              state_d        = StRdPal;
            end else begin
              state_d = StWrPal;
            end
          end
          StWrPal: begin
            unique case (cnt_q)
              2'd0: begin
                pal_d[23:16] = rx_byte;
                cnt_d        = 2'd1;
              end
              2'd1: begin
                pal_d[15:8] = rx_byte;
                cnt_d       = 2'd2;
              end
              default: begin
                palette_addr_d  = idx_q;
                palette_wdata_d = {pal_q[23:8], rx_byte};
                wren_palette_d  = 1'b1;
                idx_d           = idx_q + 8'd1;
                cnt_d           = 2'd0;
              end
            endcase
          end
          StRdPal: begin
            unique case (cnt_q)
              2'd0: begin
                tx_byte_d  = pal_q[15:8];
                tx_valid_d = 1'b1;
                cnt_d      = 2'd1;
              end
              2'd1: begin
                tx_byte_d  = pal_q[7:0];
                tx_valid_d = 1'b1;
                cnt_d      = 2'd2;
              end
              default: begin
                tx_valid_d     = 1'b0;
                idx_d          = idx_q + 8'd1;
                palette_addr_d = idx_q + 8'd1;
                pend_d[0]      = 1'b1;
                cnt_d          = 2'd0;
              end
            endcase
          end
          StStatus: begin
            err_d      = 1'b0;
            tx_byte_d  = status_byte(VERSION, 1'b0, vblank_s, hblank_s);
            tx_valid_d = 1'b1;
          end
          StIgnore: ;
          default: state_d = StIdle;
        endcase
      end
    end
  end

  assign tx_byte       = tx_byte_q;
  assign tx_valid      = tx_valid_q;
  assign rgb_addr      = rgb_addr_q;
  assign rgb_wdata     = rgb_wdata_q;
  assign wren_rgb      = wren_rgb_q;
  assign palette_addr  = palette_addr_q;
  assign palette_wdata = palette_wdata_q;
  assign wren_palette  = wren_palette_q;

endmodule

// File: tb/tb_fb_spi_cmd_writer.sv
// Directed bench for fb_spi_cmd_writer with behavioural framebuffer and palette memories.
module tb_fb_spi_cmd_writer;

  logic        clk_spi = 1'b0;
  logic        rst_n;
  logic        cs_n;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic [16:0] rgb_addr;
  logic [7:0]  rgb_wdata;
  logic        wren_rgb;
  logic [7:0]  rgb_rdata;
  logic [7:0]  palette_addr;
  logic [23:0] palette_wdata;
  logic        wren_palette;
  logic [23:0] palette_rdata;
  logic        hblank_in;
  logic        vblank_in;

  int checks = 0;
  int errors = 0;

  fb_spi_cmd_writer dut (
    .clk_spi      (clk_spi),
    .rst_n        (rst_n),
    .cs_n         (cs_n),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .tx_byte      (tx_byte),
    .tx_valid     (tx_valid),
    .rgb_addr     (rgb_addr),
    .rgb_wdata    (rgb_wdata),
    .wren_rgb     (wren_rgb),
    .rgb_rdata    (rgb_rdata),
    .palette_addr (palette_addr),
    .palette_wdata(palette_wdata),
    .wren_palette (wren_palette),
    .palette_rdata(palette_rdata),
    .hblank_in    (hblank_in),
    .vblank_in    (vblank_in)
  );

  always #5 clk_spi = ~clk_spi;

  // Memory models with registered 1-cycle reads plus a bench-side preload port.
  logic [7:0]  fb_mem [0:76799];
  logic [23:0] pal_mem [0:255];
  logic        fb_bd_we = 1'b0;
  logic [16:0] fb_bd_addr = '0;
  logic [7:0]  fb_bd_data = '0;
  logic        pal_bd_we = 1'b0;
  logic [7:0]  pal_bd_addr = '0;
  logic [23:0] pal_bd_data = '0;

  always @(posedge clk_spi) begin
    rgb_rdata <= fb_mem[rgb_addr];
    if (wren_rgb) fb_mem[rgb_addr] <= rgb_wdata;
    if (fb_bd_we) fb_mem[fb_bd_addr] <= fb_bd_data;
  end

  always @(posedge clk_spi) begin
    palette_rdata <= pal_mem[palette_addr];
    if (wren_palette) pal_mem[palette_addr] <= palette_wdata;
    if (pal_bd_we) pal_mem[pal_bd_addr] <= pal_bd_data;
  end

  logic [24:0] wr_log[$];
  logic [31:0] pal_log[$];

  always @(negedge clk_spi) begin
    if (wren_rgb) wr_log.push_back({rgb_addr, rgb_wdata});
    if (wren_palette) pal_log.push_back({palette_addr, palette_wdata});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input string tag, input logic [16:0] a, input logic [7:0] d);
    logic [24:0] got;
    got = (wr_log.size() != 0) ? wr_log.pop_front() : 25'h1FFFFFF;
    check(tag, 32'(got), 32'({a, d}));
  endtask

  task automatic expect_pal(input string tag, input logic [7:0] i, input logic [23:0] d);
    logic [31:0] got;
    got = (pal_log.size() != 0) ? pal_log.pop_front() : 32'hFFFFFFFF;
    check(tag, got, {i, d});
  endtask

  task automatic pulse(input logic [7:0] b);
    @(negedge clk_spi);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk_spi);
    rx_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk_spi);
  endtask

  task automatic send(input logic [7:0] b);
    pulse(b);
    gap(3);
  endtask

  task automatic cs_low();
    @(negedge clk_spi);
    cs_n = 1'b0;
  endtask

  task automatic cs_high();
    @(negedge clk_spi);
    cs_n = 1'b1;
    gap(2);
  endtask

  task automatic fb_poke(input logic [16:0] a, input logic [7:0] d);
    @(negedge clk_spi);
    fb_bd_we = 1'b1; fb_bd_addr = a; fb_bd_data = d;
    @(negedge clk_spi);
    fb_bd_we = 1'b0;
  endtask

  task automatic pal_poke(input logic [7:0] a, input logic [23:0] d);
    @(negedge clk_spi);
    pal_bd_we = 1'b1; pal_bd_addr = a; pal_bd_data = d;
    @(negedge clk_spi);
    pal_bd_we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; cs_n = 1'b1; rx_byte = '0; rx_valid = 1'b0;
    hblank_in = 1'b0; vblank_in = 1'b0;
    gap(4);
    check("rst_tx_byte", 32'(tx_byte), 0);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_rgb_addr", 32'(rgb_addr), 0);
    check("rst_rgb_wdata", 32'(rgb_wdata), 0);
    check("rst_wren_rgb", 32'(wren_rgb), 0);
    check("rst_pal_addr", 32'(palette_addr), 0);
    check("rst_pal_wdata", 32'(palette_wdata), 0);
    check("rst_wren_pal", 32'(wren_palette), 0);
    rst_n = 1'b1;
    gap(2);

    // Basic write burst at 0x10
    cs_low();
    send(8'h01); send(8'h00); send(8'h00); send(8'h10);
    pulse(8'hAA);
    check("wr1_wren", 32'(wren_rgb), 1);
    check("wr1_addr", 32'(rgb_addr), 32'h10);
    check("wr1_data", 32'(rgb_wdata), 32'hAA);
    gap(1);
    check("wr1_wren_drop", 32'(wren_rgb), 0);
    gap(2);
    send(8'hBB);
    cs_high();
    expect_wr("wr1_log0", 17'h10, 8'hAA);
    expect_wr("wr1_log1", 17'h11, 8'hBB);
    check("wr1_log_empty", 32'(wr_log.size()), 0);

    // Write at last framebuffer address wraps to 0
    cs_low();
    send(8'h01); send(8'h01); send(8'h2B); send(8'hFF);
    send(8'h11); send(8'h22);
    cs_high();
    expect_wr("wrap_log0", 17'd76799, 8'h11);
    expect_wr("wrap_log1", 17'd0, 8'h22);
    check("wrap_log_empty", 32'(wr_log.size()), 0);
    cs_low();
    send(8'h05);
    check("stat_noerr_byte", 32'(tx_byte), 32'h10);
    check("stat_noerr_valid", 32'(tx_valid), 1);
    cs_high();
    check("cs_high_txv", 32'(tx_valid), 0);

    // Out-of-range read address clamps to 0 and sets err
    fb_poke(17'd0, 8'h5A);
    fb_poke(17'd1, 8'h77);
    cs_low();
    send(8'h02); send(8'h03); send(8'hFF);
    pulse(8'hFF);
    check("rd_addr_clamp", 32'(rgb_addr), 0);
    check("rd_txv_c1", 32'(tx_valid), 0);
    check("rd_wren_off", 32'(wren_rgb), 0);
    gap(1);
    check("rd_txv_c2", 32'(tx_valid), 0);
    gap(1);
    check("rd_txv_c3", 32'(tx_valid), 1);
    check("rd_data0", 32'(tx_byte), 32'h5A);
    gap(1);
    pulse(8'h00);
    check("rd_next_txv_drop", 32'(tx_valid), 0);
    check("rd_next_addr", 32'(rgb_addr), 1);
    gap(2);
    check("rd_next_txv", 32'(tx_valid), 1);
    check("rd_data1", 32'(tx_byte), 32'h77);
    cs_high();
    cs_low();
    send(8'h05);
    check("stat_err_set", 32'(tx_byte), 32'h14);
    send(8'h00);
    check("stat_err_resample", 32'(tx_byte), 32'h10);
    cs_high();
    cs_low();
    send(8'h05);
    check("stat_err_cleared", 32'(tx_byte), 32'h10);
    cs_high();

    // Palette writes across index wrap
    cs_low();
    send(8'h03); send(8'hFE);
    send(8'h10); send(8'h20); send(8'h30);
    send(8'h40); send(8'h50); send(8'h60);
    send(8'h70); send(8'h80); send(8'h90);
    cs_high();
    expect_pal("pal_wr_fe", 8'hFE, 24'h102030);
    expect_pal("pal_wr_ff", 8'hFF, 24'h405060);
    expect_pal("pal_wr_00", 8'h00, 24'h708090);
    check("pal_log_empty", 32'(pal_log.size()), 0);

    // Palette read with auto-increment prefetch
    pal_poke(8'h07, 24'hABCDEF);
    pal_poke(8'h08, 24'h123456);
    cs_low();
    send(8'h04);
    pulse(8'h07);
    check("prd_addr", 32'(palette_addr), 7);
    check("prd_txv_c1", 32'(tx_valid), 0);
    gap(2);
    check("prd_txv_c3", 32'(tx_valid), 1);
    check("prd_r", 32'(tx_byte), 32'hAB);
    gap(1);
    send(8'h00);
    check("prd_g", 32'(tx_byte), 32'hCD);
    send(8'h00);
    check("prd_b", 32'(tx_byte), 32'hEF);
    pulse(8'h00);
    check("prd_next_txv_drop", 32'(tx_valid), 0);
    check("prd_next_addr", 32'(palette_addr), 8);
    gap(2);
    check("prd_next_r", 32'(tx_byte), 32'h12);
    check("prd_next_txv", 32'(tx_valid), 1);
    gap(1);
    send(8'h00);
    check("prd_next_g", 32'(tx_byte), 32'h34);
    cs_high();
    check("pal_rd_no_wr", 32'(pal_log.size()), 0);

    // Partial triplet discarded on deselect
    cs_low();
    send(8'h03); send(8'h05); send(8'h11); send(8'h22);
    cs_high();
    check("pal_partial_none", 32'(pal_log.size()), 0);
    cs_low();
    send(8'h03); send(8'h05); send(8'h33); send(8'h44); send(8'h55);
    cs_high();
    expect_pal("pal_after_abort", 8'h05, 24'h334455);

    // rx_valid coincident with cs_n high is dropped; unknown opcode ignored
    cs_low();
    send(8'h01); send(8'h00); send(8'h00); send(8'h20);
    @(negedge clk_spi);
    cs_n = 1'b1; rx_byte = 8'hCC; rx_valid = 1'b1;
    @(negedge clk_spi);
    rx_valid = 1'b0;
    check("cs_rx_drop_wren", 32'(wren_rgb), 0);
    gap(2);
    cs_low();
    send(8'h99); send(8'h01); send(8'h00); send(8'h00); send(8'h00); send(8'h55);
    cs_high();
    check("drop_ignore_log", 32'(wr_log.size()), 0);

    // Blank flag synchronizers
    cs_low();
    send(8'h05);
    check("sync_base", 32'(tx_byte), 32'h10);
    @(negedge clk_spi);
    vblank_in = 1'b1;
    pulse(8'h00);
    check("sync_vb_not_yet", 32'(tx_byte), 32'h10);
    gap(3);
    send(8'h00);
    check("sync_vb_seen", 32'(tx_byte), 32'h12);
    hblank_in = 1'b1;
    gap(3);
    send(8'h00);
    check("sync_hb_seen", 32'(tx_byte), 32'h13);
    cs_high();
    check("final_txv", 32'(tx_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
